// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: opcodes, encoder format codes, encoder FSM states.
package riscv_pkg;

  // Major opcodes, shared with the control decoder
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_OPIMM  = 7'd19;

  // Format class codes on the encoder fmt input; 9..15 are illegal
  localparam logic [3:0] FMT_R      = 4'd0;
  localparam logic [3:0] FMT_LOAD   = 4'd1;
  localparam logic [3:0] FMT_STORE  = 4'd2;
  localparam logic [3:0] FMT_BRANCH = 4'd3;
  localparam logic [3:0] FMT_LUI    = 4'd4;
  localparam logic [3:0] FMT_AUIPC  = 4'd5;
  localparam logic [3:0] FMT_JAL    = 4'd6;
  localparam logic [3:0] FMT_JALR   = 4'd7;
  localparam logic [3:0] FMT_OPIMM  = 4'd8;

  // Encoder FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENCODE = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  // Opcode for a format class; illegal classes map to zero
  function automatic logic [6:0] fmt_opcode(input logic [3:0] fmt);
    case (fmt)
      FMT_R:      return OP_R;
      FMT_LOAD:   return OP_LOAD;
      FMT_STORE:  return OP_STORE;
      FMT_BRANCH: return OP_BRANCH;
      FMT_LUI:    return OP_LUI;
      FMT_AUIPC:  return OP_AUIPC;
      FMT_JAL:    return OP_JAL;
      FMT_JALR:   return OP_JALR;
      FMT_OPIMM:  return OP_OPIMM;
      default:    return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Places immediate bits (and the shift funct7) into their word positions and range-checks them.
module rv_imm_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_err
);

  logic signed [31:0] imm_s;
  assign imm_s = imm;

  // Per-format scatter of the immediate and legality of its value
  always_comb begin
    imm_bits  = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_LOAD, FMT_JALR: begin
        imm_bits[31:20] = imm[11:0];
        range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_bits[31:25] = funct7;
          imm_bits[24:20] = imm[4:0];
          range_err = (imm > 32'd31);
        end else begin
          imm_bits[31:20] = imm[11:0];
          range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        end
      end
      FMT_STORE: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_BRANCH: begin
        imm_bits[31:25] = {imm[12], imm[10:5]};
        imm_bits[11:7]  = {imm[4:1], imm[11]};
        range_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      end
      FMT_LUI, FMT_AUIPC: begin
        imm_bits[31:12] = imm[31:12];
        range_err = |imm[11:0];
      end
      FMT_JAL: begin
        imm_bits[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
        range_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      end
      default: begin
        imm_bits  = '0;
        range_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Assembles RV32I words from decoded fields and writes them to imem at an auto-incrementing address.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned INSTRUCTION_LEN = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned BASE_ADDR       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 fmt,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       imem_we,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  output logic [INSTRUCTION_LEN-1:0] imem_wdata,
  input  logic                       imem_ready,
  output logic [15:0]                instr_count,
  output logic                       err_illegal,
  output logic                       err_imm_range,
  input  logic                       clr_err
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 fmt_q, fmt_d;
  logic [4:0]                 rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]                 f3_q, f3_d;
  logic [6:0]                 f7_q, f7_d;
  logic [31:0]                imm_q, imm_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [INSTRUCTION_LEN-1:0] wdata_q, wdata_d;
  logic [15:0]                count_q, count_d;
  logic                       ill_q, ill_d, rng_q, rng_d;

  logic [31:0] imm_bits, word;
  logic        range_err, legal;

  rv_imm_pack u_imm_pack (
    .fmt       (fmt_q),
    .funct3    (f3_q),
    .funct7    (f7_q),
    .imm       (imm_q),
    .imm_bits  (imm_bits),
    .range_err (range_err)
  );

  // Word assembly from the captured fields
  always_comb begin
    legal = (fmt_q <= FMT_OPIMM);
    word  = imm_bits;
    word[6:0] = fmt_opcode(fmt_q);
    if (legal && fmt_q != FMT_STORE && fmt_q != FMT_BRANCH)
      word[11:7] = rd_q;
    if (fmt_q == FMT_R || fmt_q == FMT_LOAD || fmt_q == FMT_STORE || fmt_q == FMT_BRANCH ||
        fmt_q == FMT_JALR || fmt_q == FMT_OPIMM) begin
      word[14:12] = f3_q;
      word[19:15] = rs1_q;
    end
    if (fmt_q == FMT_R || fmt_q == FMT_STORE || fmt_q == FMT_BRANCH)
      word[24:20] = rs2_q;
    if (fmt_q == FMT_R)
      word[31:25] = f7_q;
  end

  // FSM, capture, counters and sticky error flags
  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    imm_d   = imm_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    ill_d   = clr_err ? 1'b0 : ill_q;
    rng_d   = clr_err ? 1'b0 : rng_q;
    case (state_q)
      ST_IDLE: begin
        // restart lands before a same-cycle capture so that word goes to BASE
        if (restart) begin
          addr_d  = BASE;
          count_d = '0;
        end
        if (in_valid) begin
          fmt_d   = fmt;
          rd_d    = rd;
          rs1_d   = rs1;
          rs2_d   = rs2;
          f3_d    = funct3;
          f7_d    = funct7;
          imm_d   = imm;
          state_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (!legal) begin
          ill_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (range_err) begin
          rng_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdata_d = word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (imem_ready) begin
          addr_d  = addr_q + ADDR_WIDTH'(4);
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fmt_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      imm_q   <= '0;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      ill_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fmt_q   <= fmt_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      ill_q   <= ill_d;
      rng_q   <= rng_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign imem_we       = (state_q == ST_WRITE);
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign instr_count   = count_q;
  assign err_illegal   = ill_q;
  assign err_imm_range = rng_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes, a monitor pops on each accepted write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, imem_ready, clr_err;
  logic [3:0]  fmt;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        in_ready, imem_we, err_illegal, err_imm_range;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] instr_count;

  logic        w_in_ready, w_imem_we, w_err_illegal, w_err_imm_range;
  logic [3:0]  w_imem_addr;
  logic [31:0] w_imem_wdata;
  logic [15:0] w_instr_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instr_encoder #(.INSTRUCTION_LEN(32), .ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .instr_count(instr_count), .err_illegal(err_illegal), .err_imm_range(err_imm_range),
    .clr_err(clr_err)
  );

  // Narrow-address copy sharing all inputs, used for the wrap check
  instr_encoder #(.INSTRUCTION_LEN(32), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut_w (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(w_imem_we), .imem_addr(w_imem_addr), .imem_wdata(w_imem_wdata), .imem_ready(imem_ready),
    .instr_count(w_instr_count), .err_illegal(w_err_illegal), .err_imm_range(w_err_imm_range),
    .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for in_ready", name);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input string name, input logic [3:0] f, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input bit exp_w, input logic [31:0] ea, input logic [31:0] ed);
    wait_idle(name);
    drive(f, d, s1, s2, f3, f7, im);
    if (exp_w) sb.push_back('{addr: ea, data: ed});
    tick();
    in_valid = 1'b0;
    wait_idle(name);
  endtask

  // Monitor: every accepted write must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && imem_we && imem_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        check("write_addr", {22'd0, imem_addr}, mon_e.addr);
        check("write_data", imem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; imem_ready = 1'b1; clr_err = 1'b0;
    fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {22'd0, imem_addr}, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    check("rst_errs", {30'd0, err_illegal, err_imm_range}, 32'd0);

    // R add with latency check
    drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    sb.push_back('{addr: 32'h0, data: 32'h002081B3});
    tick();
    in_valid = 1'b0;
    check("lat_encode_we", {31'd0, imem_we}, 32'd0);
    tick();
    check("lat_write_we", {31'd0, imem_we}, 32'd1);
    check("lat_write_data", imem_wdata, 32'h002081B3);
    tick();
    check("add_count", {16'd0, instr_count}, 32'd1);
    check("add_addr_next", {22'd0, imem_addr}, 32'h4);

    send("addi", 4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'h4, 32'hFFF00093);
    send("lui", 4'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h8, 32'h123452B7);
    send("beq", 4'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hC, 32'hFE000EE3);
    check("count_after_beq", {16'd0, instr_count}, 32'd4);

    // Odd branch offset: flagged, no write
    send("beq_odd", 4'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0, 32'h0);
    check("beq_odd_err", {31'd0, err_imm_range}, 32'd1);
    check("beq_odd_addr", {22'd0, imem_addr}, 32'h10);
    check("beq_odd_count", {16'd0, instr_count}, 32'd4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_range", {31'd0, err_imm_range}, 32'd0);

    // Illegal format
    send("illegal", 4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0, 32'h0);
    check("illegal_err", {31'd0, err_illegal}, 32'd1);
    send("beq_odd2", 4'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0, 32'h0);
    // clr_err on the edge the next illegal is detected: set wins, the other flag clears
    wait_idle("illegal_clr");
    drive(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins_illegal", {31'd0, err_illegal}, 32'd1);
    check("clr_range_same_edge", {31'd0, err_imm_range}, 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_illegal", {31'd0, err_illegal}, 32'd0);
    check("addr_after_errors", {22'd0, imem_addr}, 32'h10);

    // Backpressure on slli x2,x2,3
    imem_ready = 1'b0;
    drive(4'd8, 5'd2, 5'd2, 5'd0, 3'd1, 7'd0, 32'd3);
    sb.push_back('{addr: 32'h10, data: 32'h00311113});
    tick();
    in_valid = 1'b0;
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      check("bp_we", {31'd0, imem_we}, 32'd1);
      check("bp_addr", {22'd0, imem_addr}, 32'h10);
      check("bp_data", imem_wdata, 32'h00311113);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    check("bp_we_4th", {31'd0, imem_we}, 32'd1);
    tick();
    check("bp_done_ready", {31'd0, in_ready}, 32'd1);
    check("bp_done_addr", {22'd0, imem_addr}, 32'h14);

    // Remaining formats
    send("sw", 4'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 1'b1, 32'h14, 32'h00512623);
    send("lw", 4'd1, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFF8, 1'b1, 32'h18, 32'hFF812303);
    send("jalr", 4'd7, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h1C, 32'h00008067);
    send("auipc", 4'd5, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 1'b1, 32'h20, 32'hFFFFF517);
    send("jal", 4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h24, 32'h008000EF);
    check("count_10", {16'd0, instr_count}, 32'd10);

    // Restart together with in_valid: word goes to BASE_ADDR
    wait_idle("restart");
    drive(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    restart = 1'b1;
    sb.push_back('{addr: 32'h0, data: 32'h00100093});
    tick();
    restart = 1'b0;
    in_valid = 1'b0;
    wait_idle("restart_done");
    check("restart_count", {16'd0, instr_count}, 32'd1);
    for (int unsigned k = 1; k < 4; k++)
      send("wrap_fill", 4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'(k * 4), 32'h00100093);
    check("wrap_narrow_addr", {28'd0, w_imem_addr}, 32'h0);
    check("wrap_wide_addr", {22'd0, imem_addr}, 32'h10);
    send("wrap_5th", 4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'h10, 32'h00100093);
    check("wrap_count", {16'd0, instr_count}, 32'd5);

    // restart ignored in WRITE, then rst aborts the stalled write
    imem_ready = 1'b0;
    drive(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_ignored_addr", {22'd0, imem_addr}, 32'h14);
    check("restart_ignored_count", {16'd0, instr_count}, 32'd5);
    check("midwrite_we", {31'd0, imem_we}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_we", {31'd0, imem_we}, 32'd0);
    check("abort_addr", {22'd0, imem_addr}, 32'h0);
    check("abort_count", {16'd0, instr_count}, 32'd0);
    check("abort_wdata", imem_wdata, 32'h0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    imem_ready = 1'b1;
    send("post_rst", 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0, 32'h002081B3);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
